// File: rtl/bsg_dmc_pearl_pkg.sv
// Shared types and helpers for the DMC pearl configuration shadow.
// Optional feature macro: BSG_DMC_PEARL_CFG_PARITY_EN (adds a trailing
// even-parity bit to every configuration frame).
package bsg_dmc_pearl_pkg;

  // Deserialiser FSM: start bit seen in IDLE, then one state per frame field
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CH   = 3'd1,
    EL   = 3'd2,
    DATA = 3'd3,
    PAR  = 3'd4
  } bsg_dmc_pearl_cfg_state_e;

  // Number of configuration elements per controller (monitor select, monitor
  // downsample, osc, sys, cfg, dly)
  localparam int bsg_dmc_pearl_cfg_els_gp = 6;

  // Index width for n items; never narrower than one bit so that
  // single-entry fields still exist on the wire
  function automatic int bsg_dmc_pearl_lg(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Largest of three field lengths, used to size the shared bit counter
  function automatic int bsg_dmc_pearl_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bsg_dmc_pearl_cfg_deser.sv
// Bit-serial configuration frame deserialiser.
// Frame: start(1) | channel | element | payload | [parity], each field LSB-first.
// Emits a single-cycle write strobe on the edge that accepts the final bit;
// w_err_o flags an out-of-range index or (with BSG_DMC_PEARL_CFG_PARITY_EN)
// a parity mismatch, in which case the write must be dropped.
module bsg_dmc_pearl_cfg_deser
  import bsg_dmc_pearl_pkg::*;
#(
  parameter int num_ch_p = 2,
  parameter int els_p    = bsg_dmc_pearl_cfg_els_gp,
  parameter int width_p  = 8,
  parameter int lg_ch_lp = bsg_dmc_pearl_lg(num_ch_p),
  parameter int lg_el_lp = bsg_dmc_pearl_lg(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                v_i,
  input  logic                data_i,
  output logic                w_v_o,
  output logic [lg_ch_lp-1:0] w_ch_o,
  output logic [lg_el_lp-1:0] w_el_o,
  output logic [width_p-1:0]  w_data_o,
  output logic                w_err_o,
  output logic                busy_o
);

  // All index and payload bits share one shift register: bits enter at the
  // top, so after the last field bit the channel sits at bit 0.
  localparam int fields_lp = lg_ch_lp + lg_el_lp + width_p;
  localparam int cnt_w_lp  = bsg_dmc_pearl_lg(bsg_dmc_pearl_max3(lg_ch_lp, lg_el_lp, width_p));

  localparam logic [cnt_w_lp-1:0] ch_last_lp   = cnt_w_lp'(lg_ch_lp - 1);
  localparam logic [cnt_w_lp-1:0] el_last_lp   = cnt_w_lp'(lg_el_lp - 1);
  localparam logic [cnt_w_lp-1:0] data_last_lp = cnt_w_lp'(width_p - 1);

`ifdef BSG_DMC_PEARL_CFG_PARITY_EN
  localparam bsg_dmc_pearl_cfg_state_e data_exit_lp = PAR;
`else
  localparam bsg_dmc_pearl_cfg_state_e data_exit_lp = IDLE;
`endif

  bsg_dmc_pearl_cfg_state_e state_reg, state_next;
  logic [cnt_w_lp-1:0]      cnt_reg, cnt_next;
  logic [fields_lp-1:0]     sr_reg, sr_next;
  logic [fields_lp-1:0]     fields;
  logic                     par_bad;
  logic                     ch_bad;
  logic                     el_bad;

  // State, bit counter and field shift register; reset aborts any partial frame
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sr_reg    <= sr_next;
    end
  end

  // Next-state: advance only on accepted bits, walking the fields in order
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sr_next    = sr_reg;
    if (v_i) begin
      case (state_reg)
        IDLE: begin
          if (data_i) begin
            state_next = CH;
            cnt_next   = '0;
          end
        end
        CH: begin
          sr_next = {data_i, sr_reg[fields_lp-1:1]};
          if (cnt_reg == ch_last_lp) begin
            state_next = EL;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + cnt_w_lp'(1);
          end
        end
        EL: begin
          sr_next = {data_i, sr_reg[fields_lp-1:1]};
          if (cnt_reg == el_last_lp) begin
            state_next = DATA;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + cnt_w_lp'(1);
          end
        end
        DATA: begin
          sr_next = {data_i, sr_reg[fields_lp-1:1]};
          if (cnt_reg == data_last_lp) begin
            state_next = data_exit_lp;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + cnt_w_lp'(1);
          end
        end
        PAR: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs: the completing bit is folded in combinationally so the write
  // lands on the same edge that accepts it
  always_comb begin
    w_v_o   = 1'b0;
    fields  = sr_reg;
    par_bad = 1'b0;
`ifdef BSG_DMC_PEARL_CFG_PARITY_EN
    w_v_o   = v_i && (state_reg == PAR);
    fields  = sr_reg;
    par_bad = ^{sr_reg, data_i};
`else
    w_v_o   = v_i && (state_reg == DATA) && (cnt_reg == data_last_lp);
    fields  = {data_i, sr_reg[fields_lp-1:1]};
`endif
  end

  assign w_ch_o   = fields[lg_ch_lp-1:0];
  assign w_el_o   = fields[lg_ch_lp +: lg_el_lp];
  assign w_data_o = fields[lg_ch_lp + lg_el_lp +: width_p];

  // Range checks exist only when the index field can encode unused values
  if ((1 << lg_ch_lp) > num_ch_p) begin : g_ch_chk
    assign ch_bad = (w_ch_o >= lg_ch_lp'(num_ch_p));
  end else begin : g_ch_full
    assign ch_bad = 1'b0;
  end

  if ((1 << lg_el_lp) > els_p) begin : g_el_chk
    assign el_bad = (w_el_o >= lg_el_lp'(els_p));
  end else begin : g_el_full
    assign el_bad = 1'b0;
  end

  assign w_err_o = ch_bad | el_bad | par_bad;
  assign busy_o  = (state_reg != IDLE);

endmodule

// File: rtl/bsg_dmc_pearl_cfg_shadow.sv
// Multi-channel double-buffered configuration shadow for the DMC pearl.
// Serial frames fill per-channel shadow registers; a commit copies one
// channel's whole shadow set to its active outputs in a single edge, so a
// controller never observes a half-updated configuration.
// Optional feature macro: BSG_DMC_PEARL_CFG_PARITY_EN.
module bsg_dmc_pearl_cfg_shadow
  import bsg_dmc_pearl_pkg::*;
#(
  parameter int num_ch_p = 2,
  parameter int els_p    = bsg_dmc_pearl_cfg_els_gp,
  parameter int width_p  = 8,
  parameter int lg_ch_lp = bsg_dmc_pearl_lg(num_ch_p)
) (
  input  logic                                        clk_i,
  input  logic                                        reset_n_i,
  input  logic                                        v_i,
  input  logic                                        data_i,
  input  logic                                        commit_v_i,
  input  logic [lg_ch_lp-1:0]                         commit_ch_i,
  output logic [num_ch_p-1:0][els_p-1:0][width_p-1:0] cfg_o,
  output logic [num_ch_p-1:0]                         pending_o,
  output logic                                        busy_o,
  output logic                                        err_o
);

  localparam int lg_el_lp = bsg_dmc_pearl_lg(els_p);

  logic                w_v;
  logic [lg_ch_lp-1:0] w_ch;
  logic [lg_el_lp-1:0] w_el;
  logic [width_p-1:0]  w_data;
  logic                w_err;
  logic                commit_oob;
  logic                err_reg;

  bsg_dmc_pearl_cfg_deser #(
    .num_ch_p (num_ch_p),
    .els_p    (els_p),
    .width_p  (width_p),
    .lg_ch_lp (lg_ch_lp),
    .lg_el_lp (lg_el_lp)
  ) deser (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .data_i    (data_i),
    .w_v_o     (w_v),
    .w_ch_o    (w_ch),
    .w_el_o    (w_el),
    .w_data_o  (w_data),
    .w_err_o   (w_err),
    .busy_o    (busy_o)
  );

  // A commit can only be out of range when the index encodes unused channels
  if ((1 << lg_ch_lp) > num_ch_p) begin : g_commit_chk
    assign commit_oob = commit_v_i && (commit_ch_i >= lg_ch_lp'(num_ch_p));
  end else begin : g_commit_full
    assign commit_oob = 1'b0;
  end

  // Sticky error: bad frame or out-of-range commit; only reset clears it
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_reg <= 1'b0;
    end else if ((w_v && w_err) || commit_oob) begin
      err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;

  genvar gi, gj;
  for (gi = 0; gi < num_ch_p; gi++) begin : g_ch
    logic write_ch;
    logic commit_ch;
    logic pending_reg;

    assign write_ch  = w_v && !w_err && (w_ch == lg_ch_lp'(gi));
    assign commit_ch = commit_v_i && (commit_ch_i == lg_ch_lp'(gi));

    // Pending tracks unpublished shadow writes; a write wins over a
    // same-edge commit because the commit publishes the pre-write value
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        pending_reg <= 1'b0;
      end else if (write_ch) begin
        pending_reg <= 1'b1;
      end else if (commit_ch) begin
        pending_reg <= 1'b0;
      end
    end

    assign pending_o[gi] = pending_reg;

    for (gj = 0; gj < els_p; gj++) begin : g_el
      logic                write_el;
      logic [width_p-1:0]  shadow_reg;
      logic [width_p-1:0]  active_reg;

      assign write_el = write_ch && (w_el == lg_el_lp'(gj));

      // Shadow element takes the frame payload; active copy samples the
      // old shadow value on commit, giving the pre-write value on collision
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          shadow_reg <= '0;
          active_reg <= '0;
        end else begin
          if (write_el) begin
            shadow_reg <= w_data;
          end
          if (commit_ch) begin
            active_reg <= shadow_reg;
          end
        end
      end

      assign cfg_o[gi][gj] = active_reg;
    end
  end

endmodule

// File: tb/tb_bsg_dmc_pearl_cfg_shadow.sv
// Self-checking bench for bsg_dmc_pearl_cfg_shadow (default parameters).
// Build with BSG_DMC_PEARL_CFG_PARITY_EN defined to exercise the parity bit.
module tb_bsg_dmc_pearl_cfg_shadow;

  localparam int NCH = 2;
  localparam int NEL = 6;
  localparam int W   = 8;

  logic                          clk_i;
  logic                          reset_n_i;
  logic                          v_i;
  logic                          data_i;
  logic                          commit_v_i;
  logic [0:0]                    commit_ch_i;
  logic [NCH-1:0][NEL-1:0][W-1:0] cfg_o;
  logic [NCH-1:0]                pending_o;
  logic                          busy_o;
  logic                          err_o;

  bsg_dmc_pearl_cfg_shadow dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (v_i),
    .data_i      (data_i),
    .commit_v_i  (commit_v_i),
    .commit_ch_i (commit_ch_i),
    .cfg_o       (cfg_o),
    .pending_o   (pending_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model
  logic [W-1:0] exp_shadow [NCH][NEL];
  logic [W-1:0] exp_cfg    [NCH][NEL];
  logic [NCH-1:0] exp_pending;
  logic           exp_err;

  typedef struct {
    int           ch;
    int           el;
    logic [W-1:0] val;
  } exp_t;
  exp_t exp_q[$];

  int n_vec;
  int n_bad;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset;
    for (int c = 0; c < NCH; c++)
      for (int e = 0; e < NEL; e++) begin
        exp_shadow[c][e] = '0;
        exp_cfg[c][e]    = '0;
      end
    exp_pending = '0;
    exp_err     = 1'b0;
    exp_q.delete();
  endtask

  // Commit in the model and queue the full expected active image
  task automatic model_commit(input int c);
    for (int e = 0; e < NEL; e++) exp_cfg[c][e] = exp_shadow[c][e];
    exp_pending[c] = 1'b0;
    for (int cc = 0; cc < NCH; cc++)
      for (int e = 0; e < NEL; e++) begin
        exp_t x;
        x.ch = cc; x.el = e; x.val = exp_cfg[cc][e];
        exp_q.push_back(x);
      end
  endtask

  task automatic build_frame(input logic [0:0] ch, input logic [2:0] el, input logic [W-1:0] d,
                             input bit flip, output logic [15:0] bits, output int n);
    bits      = '0;
    bits[0]   = 1'b1;
    bits[1]   = ch;
    bits[4:2] = el;
    bits[12:5] = d;
    n = 13;
`ifdef BSG_DMC_PEARL_CFG_PARITY_EN
    bits[13] = (^{ch, el, d}) ^ flip;
    n = 14;
`endif
  endtask

  // Drive one frame; optional idle gap after bit gap_after, optional commit
  // on the edge accepting the final bit
  task automatic send_frame(input logic [0:0] ch, input logic [2:0] el, input logic [W-1:0] d,
                            input bit flip, input int gap_after, input int gap_len,
                            input bit do_commit, input logic [0:0] cch);
    logic [15:0] bits;
    int n;
    bit ok;
    build_frame(ch, el, d, flip, bits, n);
    $display("frame ch=%0d el=%0d data=%h flip=%0d commit=%0d", ch, el, d, flip, do_commit);
    for (int i = 0; i < n; i++) begin
      v_i    = 1'b1;
      data_i = bits[i];
      if (i == n - 1 && do_commit) begin
        commit_v_i  = 1'b1;
        commit_ch_i = cch;
        model_commit(int'(cch));
      end
      tick;
      v_i        = 1'b0;
      data_i     = 1'b0;
      commit_v_i = 1'b0;
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          tick;
          n_vec++;
          if (busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_gap got %b expected 1", busy_o);
          end
        end
      end
    end
    ok = (el < NEL) && !flip;
    if (ok) begin
      exp_shadow[ch][el] = d;
      exp_pending[ch]    = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic commit_only(input logic [0:0] c);
    $display("commit ch=%0d", c);
    commit_v_i  = 1'b1;
    commit_ch_i = c;
    model_commit(int'(c));
    tick;
    commit_v_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_n_i = 1'b0;
    model_reset();
    tick; tick;
    n_vec++;
    if (cfg_o !== '0 || pending_o !== 2'b00 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset got cfg=%h pend=%b busy=%b err=%b expected all 0", cfg_o, pending_o, busy_o, err_o);
    end
    reset_n_i = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    exp_t x;
    send_frame(1'b1, 3'd3, 8'hA5, 1'b0, -1, 0, 1'b0, 1'b0);
    n_vec++;
    if (pending_o !== exp_pending || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pending got pend=%b busy=%b expected pend=%b busy=0", pending_o, busy_o, exp_pending);
    end
    commit_only(1'b1);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_vec++;
      if (cfg_o[x.ch][x.el] !== x.val) begin
        n_bad++;
        $display("FAIL basic_cfg[%0d][%0d] got %h expected %h", x.ch, x.el, cfg_o[x.ch][x.el], x.val);
      end
    end
    n_vec++;
    if (pending_o !== exp_pending || err_o !== exp_err) begin
      n_bad++;
      $display("FAIL basic_after got pend=%b err=%b expected pend=%b err=%b", pending_o, err_o, exp_pending, exp_err);
    end
  endtask

  task automatic test_gaps;
    exp_t x;
    int pos;
    pos = $urandom_range(6, 11);
    send_frame(1'b1, 3'd3, 8'hC3, 1'b0, pos, 5, 1'b0, 1'b0);
    n_vec++;
    if (pending_o !== exp_pending) begin
      n_bad++;
      $display("FAIL gaps_pending got %b expected %b", pending_o, exp_pending);
    end
    commit_only(1'b1);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_vec++;
      if (cfg_o[x.ch][x.el] !== x.val) begin
        n_bad++;
        $display("FAIL gaps_cfg[%0d][%0d] got %h expected %h", x.ch, x.el, cfg_o[x.ch][x.el], x.val);
      end
    end
  endtask

  task automatic test_bad_el;
    exp_t x;
    send_frame(1'b0, 3'd7, 8'hFF, 1'b0, -1, 0, 1'b0, 1'b0);
    n_vec++;
    if (err_o !== 1'b1 || pending_o !== exp_pending) begin
      n_bad++;
      $display("FAIL bad_el got err=%b pend=%b expected err=1 pend=%b", err_o, pending_o, exp_pending);
    end
    tick; tick; tick;
    n_vec++;
    if (err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky got %b expected 1", err_o);
    end
    commit_only(1'b0);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_vec++;
      if (cfg_o[x.ch][x.el] !== x.val) begin
        n_bad++;
        $display("FAIL bad_el_cfg[%0d][%0d] got %h expected %h", x.ch, x.el, cfg_o[x.ch][x.el], x.val);
      end
    end
  endtask

  task automatic test_collision;
    exp_t x;
    send_frame(1'b0, 3'd0, 8'h11, 1'b0, -1, 0, 1'b0, 1'b0);
    commit_only(1'b0);
    exp_q.delete();
    send_frame(1'b0, 3'd0, 8'h3C, 1'b0, -1, 0, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_vec++;
      if (cfg_o[x.ch][x.el] !== x.val) begin
        n_bad++;
        $display("FAIL collide_cfg[%0d][%0d] got %h expected %h", x.ch, x.el, cfg_o[x.ch][x.el], x.val);
      end
    end
    n_vec++;
    if (pending_o[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL collide_pending got %b expected 1", pending_o[0]);
    end
    commit_only(1'b0);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_vec++;
      if (cfg_o[x.ch][x.el] !== x.val) begin
        n_bad++;
        $display("FAIL collide2_cfg[%0d][%0d] got %h expected %h", x.ch, x.el, cfg_o[x.ch][x.el], x.val);
      end
    end
    n_vec++;
    if (pending_o !== exp_pending) begin
      n_bad++;
      $display("FAIL collide2_pending got %b expected %b", pending_o, exp_pending);
    end
  endtask

  task automatic test_reset_midframe;
    exp_t x;
    logic [15:0] bits;
    int n;
    build_frame(1'b1, 3'd2, 8'hE7, 1'b0, bits, n);
    $display("partial frame ch=1 el=2 data=e7 aborted by reset");
    for (int i = 0; i < 7; i++) begin
      v_i    = 1'b1;
      data_i = bits[i];
      tick;
    end
    reset_n_i = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (cfg_o !== '0 || pending_o !== 2'b00 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset got cfg=%h pend=%b busy=%b err=%b expected all 0", cfg_o, pending_o, busy_o, err_o);
    end
    v_i = 1'b0;
    data_i = 1'b0;
    tick;
    reset_n_i = 1'b1;
    tick;
    send_frame(1'b1, 3'd2, 8'hE7, 1'b0, -1, 0, 1'b0, 1'b0);
    commit_only(1'b1);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_vec++;
      if (cfg_o[x.ch][x.el] !== x.val) begin
        n_bad++;
        $display("FAIL midreset_cfg[%0d][%0d] got %h expected %h", x.ch, x.el, cfg_o[x.ch][x.el], x.val);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t x;
    send_frame(1'b0, 3'd1, 8'h12, 1'b0, -1, 0, 1'b0, 1'b0);
    send_frame(1'b1, 3'd4, 8'h34, 1'b0, -1, 0, 1'b0, 1'b0);
    send_frame(1'b0, 3'd5, 8'h56, 1'b0, -1, 0, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_vec++;
      if (cfg_o[x.ch][x.el] !== x.val) begin
        n_bad++;
        $display("FAIL b2b_cfg[%0d][%0d] got %h expected %h", x.ch, x.el, cfg_o[x.ch][x.el], x.val);
      end
    end
    n_vec++;
    if (pending_o !== exp_pending || err_o !== exp_err) begin
      n_bad++;
      $display("FAIL b2b_pending got pend=%b err=%b expected pend=%b err=%b", pending_o, err_o, exp_pending, exp_err);
    end
    commit_only(1'b0);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_vec++;
      if (cfg_o[x.ch][x.el] !== x.val) begin
        n_bad++;
        $display("FAIL b2b2_cfg[%0d][%0d] got %h expected %h", x.ch, x.el, cfg_o[x.ch][x.el], x.val);
      end
    end
  endtask

`ifdef BSG_DMC_PEARL_CFG_PARITY_EN
  task automatic test_parity;
    exp_t x;
    send_frame(1'b1, 3'd0, 8'h81, 1'b0, -1, 0, 1'b0, 1'b0);
    n_vec++;
    if (pending_o !== exp_pending || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL parity_good got pend=%b err=%b expected pend=%b err=0", pending_o, err_o, exp_pending);
    end
    send_frame(1'b1, 3'd0, 8'h7E, 1'b1, -1, 0, 1'b0, 1'b0);
    n_vec++;
    if (err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL parity_bad got err=%b expected 1", err_o);
    end
    commit_only(1'b1);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_vec++;
      if (cfg_o[x.ch][x.el] !== x.val) begin
        n_bad++;
        $display("FAIL parity_cfg[%0d][%0d] got %h expected %h", x.ch, x.el, cfg_o[x.ch][x.el], x.val);
      end
    end
  endtask
`endif

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    reset_n_i   = 1'b0;
    v_i         = 1'b0;
    data_i      = 1'b0;
    commit_v_i  = 1'b0;
    commit_ch_i = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_bad_el();
    test_collision();
    test_reset_midframe();
    test_back_to_back();
`ifdef BSG_DMC_PEARL_CFG_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
